// File: rtl/multdiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide engine:
// state encodings, widths and iteration count.
package multdiv_defs;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITERS = 32;
    localparam int MD_CNT_W = $clog2(MD_ITERS);

    localparam logic [31:0] MD_INT_MIN = 32'h8000_0000;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_MULT = 2'd1;
    localparam logic [1:0] MD_DIV  = 2'd2;
    localparam logic [1:0] MD_DONE = 2'd3;

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter for the multiply/divide engine: cleared on a start,
// advances once per radix-2 step, flags the final step.
module multdiv_counter
    import multdiv_defs::*;
(
    input  logic clk,
    input  logic clr_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_last
);

    logic [MD_CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + MD_CNT_W'(1);
        end
    end

    assign o_last = (r_count == MD_CNT_W'(MD_ITERS - 1));

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide engine with a fixed 32-cycle latency.
// state     | meaning
// MD_IDLE   | waiting for a start pulse
// MD_MULT   | shift-add step on operand magnitudes
// MD_DIV    | restoring-division step on operand magnitudes
// MD_DONE   | rdy high for one cycle, result/exception valid
module multdiv_unit
    import multdiv_defs::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             rdy,
    output logic             busy
);

    logic [1:0]  r_state;
    logic [63:0] r_acc;
    logic [31:0] r_opnd;
    logic        r_neg;
    logic        r_div_zero;
    logic        r_div_ovf;
    logic [31:0] r_result;
    logic        r_exc;
    logic        r_rdy;
    logic        r_busy;

    logic        w_start;
    logic        w_stepping;
    logic        w_last;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_nxt;
    logic [63:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic [63:0] w_div_nxt;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic        w_mul_ovf;

    assign w_start    = ctrl_mult | ctrl_div;
    assign w_stepping = (r_state == MD_MULT) || (r_state == MD_DIV);
    assign w_abs_a    = operand_a[31] ? -operand_a : operand_a;
    assign w_abs_b    = operand_b[31] ? -operand_b : operand_b;

    multdiv_counter u_counter (
        .clk     (clk),
        .clr_n   (clr_n),
        .i_clear (w_start),
        .i_en    (w_stepping),
        .o_last  (w_last)
    );

    // Multiply: r_acc low half holds the multiplier, shifted out as the
    // partial product grows into the high half. Divide: r_acc low half holds
    // the dividend, shifted into the remainder while quotient bits fill in.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
        w_mul_nxt   = {w_mul_sum, r_acc[31:1]};
        w_div_shift = {r_acc[62:0], 1'b0};
        w_div_diff  = {1'b0, w_div_shift[63:32]} - {1'b0, r_opnd};
        w_div_nxt   = w_div_diff[32] ? w_div_shift
                                     : {w_div_diff[31:0], w_div_shift[31:1], 1'b1};
        w_prod      = r_neg ? -w_mul_nxt : w_mul_nxt;
        w_quot      = r_neg ? -w_div_nxt[31:0] : w_div_nxt[31:0];
        w_mul_ovf   = ~((&w_prod[63:31]) | ~(|w_prod[63:31]));
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= MD_IDLE;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_neg      <= 1'b0;
            r_div_zero <= 1'b0;
            r_div_ovf  <= 1'b0;
            r_result   <= '0;
            r_exc      <= 1'b0;
            r_rdy      <= 1'b0;
            r_busy     <= 1'b0;
        end else if (w_start) begin
            r_state    <= ctrl_mult ? MD_MULT : MD_DIV;
            r_acc      <= {32'd0, ctrl_mult ? w_abs_b : w_abs_a};
            r_opnd     <= ctrl_mult ? w_abs_a : w_abs_b;
            r_neg      <= operand_a[31] ^ operand_b[31];
            r_div_zero <= (operand_b == '0);
            r_div_ovf  <= (operand_a == MD_INT_MIN) && (&operand_b);
            r_rdy      <= 1'b0;
            r_busy     <= 1'b1;
        end else begin
            case (r_state)
                MD_MULT, MD_DIV: begin
                    r_acc <= (r_state == MD_DIV) ? w_div_nxt : w_mul_nxt;
                    if (w_last) begin
                        r_state <= MD_DONE;
                        r_busy  <= 1'b0;
                        r_rdy   <= 1'b1;
                        if (r_state == MD_MULT) begin
                            r_result <= w_prod[31:0];
                            r_exc    <= w_mul_ovf;
                        end else if (r_div_zero) begin
                            r_result <= '0;
                            r_exc    <= 1'b1;
                        end else if (r_div_ovf) begin
                            r_result <= MD_INT_MIN;
                            r_exc    <= 1'b1;
                        end else begin
                            r_result <= w_quot;
                            r_exc    <= 1'b0;
                        end
                    end
                end
                MD_DONE: begin
                    r_state <= MD_IDLE;
                    r_rdy   <= 1'b0;
                end
                default: begin
                    r_state <= MD_IDLE;
                end
            endcase
        end
    end

    assign result    = r_result;
    assign exception = r_exc;
    assign rdy       = r_rdy;
    assign busy      = r_busy;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed-vector bench for multdiv_unit: latency, busy/rdy framing,
// signed results, exceptions, restart and asynchronous reset.
module tb_multdiv_unit;

    logic        clk;
    logic        clr_n;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic [31:0] result;
    logic        exception;
    logic        rdy;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .ctrl_mult (ctrl_mult),
        .ctrl_div  (ctrl_div),
        .result    (result),
        .exception (exception),
        .rdy       (rdy),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Start pulse: set up in the cycle before the edge, drop 1 ns after it.
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ctrl_mult = m;
        ctrl_div  = d;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
    endtask

    // Observes cycles 0..33 after the most recent start edge.
    task automatic watch_op(input string tag, input logic [31:0] prev_res,
                            input logic [31:0] exp_res, input logic exp_exc);
        int          rdy_cnt;
        int          rdy_at;
        int          busy_bad;
        int          hold_bad;
        logic [31:0] got_res;
        logic        got_exc;
        rdy_cnt  = 0;
        rdy_at   = -1;
        busy_bad = 0;
        hold_bad = 0;
        got_res  = '0;
        got_exc  = 1'b0;
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            if (rdy) begin
                rdy_cnt++;
                rdy_at  = k;
                got_res = result;
                got_exc = exception;
            end
            if (busy !== (k < 32)) busy_bad++;
            if (k < 32 && result !== prev_res) hold_bad++;
        end
        check_val({tag, "_rdy_count"}, 32'(rdy_cnt), 32'd1);
        check_val({tag, "_rdy_cycle"}, 32'(rdy_at), 32'd32);
        check_val({tag, "_result"}, got_res, exp_res);
        check_val({tag, "_exception"}, {31'd0, got_exc}, {31'd0, exp_exc});
        check_val({tag, "_busy_frame"}, 32'(busy_bad), 32'd0);
        check_val({tag, "_result_hold"}, 32'(hold_bad), 32'd0);
    endtask

    task automatic do_op(input string tag, input logic m, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_exc);
        logic [31:0] prev;
        prev = result;
        start_op(m, ~m, a, b);
        watch_op(tag, prev, exp_res, exp_exc);
    endtask

    initial begin
        logic [31:0] prev;
        int          rdy_seen;
        clr_n     = 1'b0;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        operand_a = '0;
        operand_b = '0;
        #12;
        check_val("reset_result", result, 32'd0);
        check_val("reset_flags", {28'd0, exception, rdy, busy, 1'b0}, 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (2) @(posedge clk);

        do_op("mul_7x-6",     1'b1, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
        do_op("mul_ovf",      1'b1, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1);
        do_op("mul_max",      1'b1, 32'h7FFF_FFFF,  32'd1,         32'h7FFF_FFFF, 1'b0);
        do_op("mul_neg_neg",  1'b1, 32'hFFFF_FFFB,  32'hFFFF_FFFB, 32'd25,        1'b0);
        do_op("mul_min_x-1",  1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        do_op("div_-100/7",   1'b0, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0);
        do_op("div_100/-7",   1'b0, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0);
        do_op("div_5/0",      1'b0, 32'd5,          32'd0,         32'd0,         1'b1);
        do_op("div_min/-1",   1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        do_op("div_-7/2",     1'b0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
        do_op("div_min/1",    1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0);
        do_op("div_0/5",      1'b0, 32'd0,          32'd5,         32'd0,         1'b0);

        // Multiply 3x4 at E0, then divide 20/3 at E10: only the divide reports.
        prev = result;
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        start_op(1'b0, 1'b1, 32'd20, 32'd3);
        watch_op("restart", prev, 32'd6, 1'b0);

        prev = result;
        start_op(1'b1, 1'b1, 32'd6, 32'd7);
        watch_op("both_ctrl", prev, 32'd42, 1'b0);

        // Asynchronous reset partway through a divide.
        start_op(1'b0, 1'b1, 32'd1000, 32'd10);
        repeat (15) @(posedge clk);
        #3;
        clr_n = 1'b0;
        #1;
        check_val("rst_mid_result", result, 32'd0);
        check_val("rst_mid_flags", {29'd0, exception, rdy, busy}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        rdy_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rdy) rdy_seen++;
        end
        check_val("rst_lost_rdy", 32'(rdy_seen), 32'd0);
        do_op("after_rst", 1'b0, 32'd1000, 32'd10, 32'd100, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
